operand_stack: RTL and testbench

Hardware operand stack serving the multicycle stack CPU's datapath: it executes the single-cycle `push`, `pop` and `tos` commands issued by the CPU control FSM. It holds operands and results and presents the top or popped word on a registered output for the A/B operand latches. Full/empty status and sticky error flags are also provided for debug and trap logic.

---
 rtl/operand_stack_if.sv | 39 +++
 rtl/operand_stack.sv | 97 +++++++++
 tb/tb_operand_stack.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// rtl/operand_stack_if.sv - command/status bundle between CPU control and the operand stack
// Purpose: groups the stack command inputs and registered/decoded status outputs.
// Ports:
//   push, pop, tos   command strobes, one per cycle at most
//   din              push data
//   err_clr          clears the sticky error flags
//   dout             registered top/popped word
//   count            valid entries, 0..DEPTH
//   empty, full      decoded from the stack pointer
//   ovf, unf, illegal  sticky error flags
interface operand_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic             illegal;

  modport master (
    output push, pop, tos, din, err_clr,
    input  dout, count, empty, full, ovf, unf, illegal
  );

  modport slave (
    input  push, pop, tos, din, err_clr,
    output dout, count, empty, full, ovf, unf, illegal
  );
endinterface

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - LIFO operand stack with registered output and sticky error flags
// Purpose: executes single-cycle push/pop/tos commands for the stack CPU datapath.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (entries discarded, outputs cleared)
//   bus   operand_stack_if.slave: commands in, dout/count/status/errors out
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  operand_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_SP = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ill_q, ill_d;

  logic             is_empty, is_full, multi, do_push;
  logic             set_ovf, set_unf;
  logic [AW-1:0]    wr_idx, top_idx;

  always_comb begin
    is_empty = (sp_q == '0);
    is_full  = (sp_q == FULL_SP);
    multi    = (bus.push & bus.pop) | (bus.push & bus.tos) | (bus.pop & bus.tos);
    // Indices are only used when the full/empty guards allow, so truncation is safe.
    wr_idx   = AW'(sp_q);
    top_idx  = AW'(sp_q - ONE);
    do_push  = bus.push & ~multi & ~is_full;

    sp_d    = sp_q;
    dout_d  = dout_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;

    // Conflicting commands are rejected outright; only 'illegal' records them.
    if (!multi) begin
      if (bus.push) begin
        if (is_full) set_ovf = 1'b1;
        else         sp_d = sp_q + ONE;
      end else if (bus.pop) begin
        if (is_empty) begin
          set_unf = 1'b1;
        end else begin
          dout_d = mem_q[top_idx];
          sp_d   = sp_q - ONE;
        end
      end else if (bus.tos) begin
        if (is_empty) set_unf = 1'b1;
        else          dout_d = mem_q[top_idx];
      end
    end

    // A new error in the clearing cycle wins over err_clr.
    ovf_d = (ovf_q & ~bus.err_clr) | set_ovf;
    unf_d = (unf_q & ~bus.err_clr) | set_unf;
    ill_d = (ill_q & ~bus.err_clr) | multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      ill_q  <= ill_d;
    end
  end

  // Storage array carries no reset; validity is tracked by sp alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= bus.din;
  end

  assign bus.dout    = dout_q;
  assign bus.count   = sp_q;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
  assign bus.ovf     = ovf_q;
  assign bus.unf     = unf_q;
  assign bus.illegal = ill_q;
endmodule

// File: tb/tb_operand_stack.sv
// tb/tb_operand_stack.sv - self-checking bench for operand_stack
module tb_operand_stack;
  logic clk;
  logic rst;

  operand_stack_if #(.WIDTH(8), .DEPTH(16)) bus ();

  operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       tos;
    logic [7:0] din;
    logic       clr;
    logic [7:0] e_dout;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_unf;
    logic       e_ill;
  } vec_t;

  vec_t        vecs [21];
  logic [17:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [17:0] ex(input logic [7:0] d, input logic [4:0] c,
                                     input logic em, input logic fu, input logic o,
                                     input logic u, input logic il);
    return {d, c, em, fu, o, u, il};
  endfunction

  function automatic logic [17:0] got();
    return {bus.dout, bus.count, bus.empty, bus.full, bus.ovf, bus.unf, bus.illegal};
  endfunction

  task automatic compare(input string name);
    logic [17:0] e;
    logic [17:0] g;
    g = got();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, g);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got dout/count/em/fu/ovf/unf/ill=%h want %h", name, g, e);
    end
  endtask

  task automatic step(input logic p, input logic po, input logic t, input logic [7:0] d,
                      input logic c, input logic [17:0] e, input string name);
    @(negedge clk);
    bus.push = p; bus.pop = po; bus.tos = t; bus.din = d; bus.err_clr = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.err_clr = 1'b0;
    compare(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        push pop tos din   clr  dout   cnt em fu ov un il
    vecs[0]  = '{1, 0, 0, 8'h11, 0, 8'h00, 5'd1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h22, 0, 8'h00, 5'd2, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'h33, 0, 8'h00, 5'd3, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 8'h00, 0, 8'h33, 5'd3, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 0, 8'h00, 0, 8'h33, 5'd2, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 8'h00, 0, 8'h22, 5'd1, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 8'h00, 0, 8'h11, 5'd0, 1, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 8'hA5, 0, 8'h11, 5'd1, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 8'h00, 0, 8'hA5, 5'd0, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 8'h00, 0, 8'hA5, 5'd0, 1, 0, 0, 1, 0};
    vecs[10] = '{0, 0, 1, 8'h00, 0, 8'hA5, 5'd0, 1, 0, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 8'h00, 1, 8'hA5, 5'd0, 1, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 0, 8'h01, 0, 8'hA5, 5'd1, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 8'h02, 0, 8'hA5, 5'd2, 0, 0, 0, 0, 0};
    vecs[14] = '{1, 1, 0, 8'h77, 0, 8'hA5, 5'd2, 0, 0, 0, 0, 1};
    vecs[15] = '{0, 0, 1, 8'h00, 0, 8'h02, 5'd2, 0, 0, 0, 0, 1};
    vecs[16] = '{0, 1, 0, 8'h00, 1, 8'h02, 5'd1, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 1, 0, 8'h00, 1, 8'h01, 5'd0, 1, 0, 0, 0, 0};
    vecs[18] = '{0, 1, 0, 8'h00, 1, 8'h01, 5'd0, 1, 0, 0, 1, 0};
    vecs[19] = '{1, 1, 1, 8'h55, 0, 8'h01, 5'd0, 1, 0, 0, 1, 1};
    vecs[20] = '{0, 0, 0, 8'h00, 1, 8'h01, 5'd0, 1, 0, 0, 0, 0};

    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.din = '0; bus.err_clr = 1'b0;
    #2;
    exp_q.push_back(ex(8'h00, 5'd0, 1, 0, 0, 0, 0));
    compare("reset_async");
    @(posedge clk);
    #1;
    exp_q.push_back(ex(8'h00, 5'd0, 1, 0, 0, 0, 0));
    compare("reset_held");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].din, vecs[i].clr,
           ex(vecs[i].e_dout, vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full,
              vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_ill),
           $sformatf("vec%0d", i));
    end

    // Fill to capacity, then overflow.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 8'(8'h40 + i), 0,
           ex(8'h01, 5'(i + 1), 0, (i == 15), 0, 0, 0), $sformatf("fill%0d", i));
    end
    step(1, 0, 0, 8'hFF, 0, ex(8'h01, 5'd16, 0, 1, 1, 0, 0), "ovf_push");
    step(0, 1, 0, 8'h00, 0, ex(8'h4F, 5'd15, 0, 0, 1, 0, 0), "ovf_pop");
    step(0, 0, 0, 8'h00, 1, ex(8'h4F, 5'd15, 0, 0, 0, 0, 0), "ovf_clr");
    for (int i = 14; i >= 0; i--) begin
      step(0, 1, 0, 8'h00, 0,
           ex(8'(8'h40 + i), 5'(i), (i == 0), 0, 0, 0, 0), $sformatf("drain%0d", i));
    end

    // Asynchronous reset between edges.
    step(1, 0, 0, 8'h10, 0, ex(8'h40, 5'd1, 0, 0, 0, 0, 0), "pre_rst_push0");
    step(1, 0, 0, 8'h20, 0, ex(8'h40, 5'd2, 0, 0, 0, 0, 0), "pre_rst_push1");
    step(0, 0, 1, 8'h00, 0, ex(8'h20, 5'd2, 0, 0, 0, 0, 0), "pre_rst_tos");
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(ex(8'h00, 5'd0, 1, 0, 0, 0, 0));
    compare("midcycle_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 8'h30, 0, ex(8'h00, 5'd1, 0, 0, 0, 0, 0), "post_rst_push");
    step(0, 0, 1, 8'h00, 0, ex(8'h30, 5'd1, 0, 0, 0, 0, 0), "post_rst_tos");
    step(0, 0, 0, 8'h00, 0, ex(8'h30, 5'd1, 0, 0, 0, 0, 0), "idle_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
